exec_controller: RTL and testbench
==================================

EXEC_CONTROLLER -- requirements
Module: exec_controller

Interface
- REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
- REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
- REQ-003 SHALL have ports instr_valid (in, 1), instr_ready (out, 1), ir (in, 32), id (in, 32): the decoded-instruction handshake, the raw instruction word and the decoded instruction ID.
- REQ-004 SHALL have ports rs_addr and rt_addr (out, 5) and rs_data and rt_data (in, 32): register-file read.
- REQ-005 SHALL have ports alu_id (out, 32), alu_a and alu_b (out, 32) and alu_result (in, 32): drive and observe the combinational ALU.
- REQ-006 SHALL have ports mem_req, mem_we (out, 1), mem_addr, mem_wdata (out, 32), mem_ack (in, 1) and mem_rdata (in, 32): data-memory request/ack.
- REQ-007 SHALL have ports rf_we (out, 1), rf_waddr (out, 5), rf_wdata (out, 32): register writeback.
- REQ-008 SHALL have ports pc_load (out, 1), pc_target (out, 32), busy (out, 1) and err (out, 1).

Function
- REQ-009 SHALL implement the states IDLE, READ, EXEC, MEM and WB; instr_ready=1 only in IDLE.
- REQ-010 SHALL capture ir and id in IDLE when instr_valid=1, then go to READ.
- REQ-011 SHALL hold instr_valid while not in IDLE with no effect.
- REQ-012 SHALL classify id as follows:
  - ALU-R: 1,3,5,7,9,11,22,23,24.
  - ALU-I: 2,4,6,8,10,12.
  - LOAD: 13.
  - STORE: 14.
  - JUMP: 21.
  - Illegal: any other value.
- REQ-013 In READ, SHALL drive rs_addr=ir[25:21] and rt_addr=ir[20:16]; register-file data is valid the following cycle.
- REQ-014 In EXEC for ALU classes, SHALL drive:
  - alu_id=id and alu_a=rs_data.
  - alu_b=rt_data for ALU-R, or sign-extended ir[15:0] for ALU-I.
  - It SHALL register alu_result and then go to WB.
- REQ-015 In WB, SHALL pulse rf_we for 1 cycle with the registered result.
  - rf_waddr=ir[15:11] for ALU-R and ir[20:16] for ALU-I.
  - Latency is accept edge to rf_we high = 3 cycles (READ, EXEC, WB).
- REQ-016 SHALL suppress rf_we when rf_waddr=0.
- REQ-017 In EXEC for LOAD/STORE, SHALL register mem_addr=rs_data+sext(ir[15:0]) (32-bit wrap) and mem_wdata=rt_data, then go to MEM.
- REQ-018 In MEM, SHALL hold mem_req=1 (mem_we=1 for STORE) with stable addr/data until a cycle with mem_ack=1.
  - mem_req SHALL drop on the next edge.
  - mem_ack received while mem_req=0 SHALL be ignored.
- REQ-019 After the ack, LOAD SHALL go to WB and write mem_rdata (captured on ack) to ir[20:16]; STORE SHALL return to IDLE with no rf_we.
- REQ-020 JUMP SHALL pulse pc_load for 1 cycle in EXEC with pc_target={6'b0, ir[25:0]}, then return to IDLE; there SHALL be no register or memory access.
- REQ-021 An illegal ID SHALL pulse err for 1 cycle in EXEC and return to IDLE, with no rf_we, mem_req or pc_load.
- REQ-022 SHALL set busy=1 in every state except IDLE.
- REQ-023 SHALL never assert more than one of rf_we, mem_req and pc_load in the same cycle.

Reset
- REQ-024 SHALL, on reset=1 at an edge, enter IDLE.
  - All outputs SHALL be 0, except instr_ready=1.
  - The captured ir/id and the timeout counter SHALL clear.
- REQ-025 Reset mid-operation (including in MEM with mem_req=1) SHALL abandon the instruction.
  - mem_req and rf_we SHALL be 0 from the next cycle.
  - No writeback SHALL occur.
- REQ-026 Reset SHALL take priority over instr_valid and mem_ack in the same cycle.

Configuration
- REQ-027 With macro EXEC_CTRL_MEM_TIMEOUT_EN defined, SHALL count MEM cycles using a 4-bit counter.
  - When 16 cycles elapse without mem_ack, it SHALL drop mem_req, pulse err for 1 cycle and return to IDLE, with no rf_we.
  - An ack arriving on the 16th cycle SHALL win over the timeout.
- REQ-028 Without EXEC_CTRL_MEM_TIMEOUT_EN, SHALL wait in MEM indefinitely, and err SHALL only flag illegal IDs.

Verification
- REQ-029 add: id=1, ir rd field=1, rs_data=10, rt_data=12 -> rf_we, rf_waddr=1, rf_wdata=22, exactly 3 cycles after accept.
- REQ-030 ori: id=10, rs_data=10, imm=99 -> alu_b=99, rf_waddr=1 (rt field), rf_wdata=109; an add with rd=0 -> no rf_we.
- REQ-031 lw 100($2): rs_data=10, mem_ack 2 cycles later with mem_rdata=0x55 -> mem_addr=110 held stable, then rf_waddr=1 and rf_wdata=0x55.
- REQ-032 sw / j:
  - sw with rs_data=10 and rt_data=12 -> mem_we=1, mem_addr=110, mem_wdata=12, no rf_we.
  - j 100 -> a single pc_load pulse with pc_target=100.
- REQ-033 Illegal / timeout:
  - id=31 -> err pulse and back to IDLE.
  - With EXEC_CTRL_MEM_TIMEOUT_EN and no ack -> err after 16 MEM cycles.
  - instr_valid held while busy -> no second capture.
- REQ-034 Reset asserted in MEM with mem_req=1 -> next cycle mem_req=0, instr_ready=1, and no rf_we ever for that instruction.

Source files
------------

// File: rtl/exec_controller.sv
// Multi-cycle execute controller: IDLE -> READ -> EXEC -> (MEM) -> (WB) for decoded instructions.
// Optional: define EXEC_CTRL_MEM_TIMEOUT_EN to abort a memory access after 16 cycles without mem_ack.
module exec_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] ir,
  input  logic [31:0] id,
  output logic [4:0]  rs_addr,
  output logic [4:0]  rt_addr,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic [31:0] alu_id,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_result,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        pc_load,
  output logic [31:0] pc_target,
  output logic        busy,
  output logic        err
);

  typedef enum logic [2:0] {IDLE, READ, EXEC, MEM, WB} state_e;
  typedef enum logic [2:0] {CLS_ALUR, CLS_ALUI, CLS_LOAD, CLS_STORE, CLS_JUMP, CLS_ILL} cls_e;

  state_e      state_q;
  logic [31:0] ir_q;
  logic [31:0] id_q;
  logic [31:0] result_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic        tmo_err_q;
`ifdef EXEC_CTRL_MEM_TIMEOUT_EN
  logic [3:0]  tmo_cnt_q;
`endif

  cls_e        cls;
  logic        is_alu;
  logic [31:0] imm_sext;
  logic [4:0]  waddr;
  logic        unused_ir;

  always_comb begin
    case (id_q)
      32'd1, 32'd3, 32'd5, 32'd7, 32'd9, 32'd11, 32'd22, 32'd23, 32'd24: cls = CLS_ALUR;
      32'd2, 32'd4, 32'd6, 32'd8, 32'd10, 32'd12:                        cls = CLS_ALUI;
      32'd13:                                                           cls = CLS_LOAD;
      32'd14:                                                           cls = CLS_STORE;
      32'd21:                                                           cls = CLS_JUMP;
      default:                                                          cls = CLS_ILL;
    endcase
  end

  assign is_alu    = (cls == CLS_ALUR) || (cls == CLS_ALUI);
  assign imm_sext  = {{16{ir_q[15]}}, ir_q[15:0]};
  assign waddr     = (cls == CLS_ALUR) ? ir_q[15:11] : ir_q[20:16];
  assign unused_ir = ^ir_q[31:26];

  // Timeout error is registered so it pulses in the first IDLE cycle after an abandoned access.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      ir_q        <= 32'd0;
      id_q        <= 32'd0;
      result_q    <= 32'd0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      tmo_err_q   <= 1'b0;
`ifdef EXEC_CTRL_MEM_TIMEOUT_EN
      tmo_cnt_q   <= 4'd0;
`endif
    end else begin
      tmo_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (instr_valid) begin
            ir_q    <= ir;
            id_q    <= id;
            state_q <= READ;
          end
        end
        READ: state_q <= EXEC;
        EXEC: begin
          case (cls)
            CLS_ALUR, CLS_ALUI: begin
              result_q <= alu_result;
              state_q  <= WB;
            end
            CLS_LOAD, CLS_STORE: begin
              mem_addr_q  <= rs_data + imm_sext;
              mem_wdata_q <= rt_data;
`ifdef EXEC_CTRL_MEM_TIMEOUT_EN
              tmo_cnt_q   <= 4'd0;
`endif
              state_q     <= MEM;
            end
            default: state_q <= IDLE;
          endcase
        end
        MEM: begin
          // An ack in the 16th cycle is checked first, so it beats the timeout.
          if (mem_ack) begin
            if (cls == CLS_LOAD) begin
              result_q <= mem_rdata;
              state_q  <= WB;
            end else begin
              state_q  <= IDLE;
            end
          end
`ifdef EXEC_CTRL_MEM_TIMEOUT_EN
          else if (tmo_cnt_q == 4'd15) begin
            tmo_err_q <= 1'b1;
            state_q   <= IDLE;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 4'd1;
          end
`endif
        end
        WB:      state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign instr_ready = (state_q == IDLE);
  assign busy        = (state_q != IDLE);

  assign rs_addr = (state_q == READ) ? ir_q[25:21] : 5'd0;
  assign rt_addr = (state_q == READ) ? ir_q[20:16] : 5'd0;

  assign alu_id = (state_q == EXEC && is_alu) ? id_q : 32'd0;
  assign alu_a  = (state_q == EXEC && is_alu) ? rs_data : 32'd0;
  assign alu_b  = (state_q == EXEC && cls == CLS_ALUR) ? rt_data :
                  (state_q == EXEC && cls == CLS_ALUI) ? imm_sext : 32'd0;

  assign mem_req   = (state_q == MEM);
  assign mem_we    = (state_q == MEM) && (cls == CLS_STORE);
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  // Writes to register 0 are dropped; the WB cycle still happens.
  assign rf_we    = (state_q == WB) && (waddr != 5'd0);
  assign rf_waddr = (state_q == WB) ? waddr : 5'd0;
  assign rf_wdata = (state_q == WB) ? result_q : 32'd0;

  assign pc_load   = (state_q == EXEC) && (cls == CLS_JUMP);
  assign pc_target = pc_load ? {6'b0, ir_q[25:0]} : 32'd0;

  assign err = ((state_q == EXEC) && (cls == CLS_ILL)) || tmo_err_q;

endmodule

// File: tb/tb_exec_controller.sv
// Self-checking bench for exec_controller: directed table, randomized vectors against a
// behavioural model of instruction timing/results, plus reset-in-MEM sequences.
module tb_exec_controller;

  logic        clk, reset, instr_valid, instr_ready;
  logic [31:0] ir, id;
  logic [4:0]  rs_addr, rt_addr;
  logic [31:0] rs_data, rt_data;
  logic [31:0] alu_id, alu_a, alu_b, alu_result;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        pc_load, busy, err;
  logic [31:0] pc_target;

  logic [31:0] regs [32];
  int vecCount = 0;
  int missCount = 0;

  typedef struct packed {
    bit          rfWe;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    int          memCycles;
    bit          memWe;
    logic [31:0] addr;
    logic [31:0] mwdata;
    bit          pc;
    logic [31:0] target;
    bit          err;
    int          busy;
    bit          alu;
    logic [31:0] aluA;
    logic [31:0] aluB;
  } exp_t;

  typedef struct packed {
    logic [31:0] id;
    logic [31:0] ir;
    logic [31:0] rsV;
    logic [31:0] rtV;
    int          d;
    logic [31:0] rdata;
    bit          hold;
    exp_t        e;
  } vec_t;

  typedef struct packed {
    bit          hung;
    int          busy;
    int          rfCnt;
    int          rfCycle;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    int          memCnt;
    logic [31:0] addr;
    logic [31:0] mwdata;
    bit          memWe;
    bit          unstable;
    int          pcCnt;
    int          pcCycle;
    logic [31:0] target;
    int          errCnt;
    int          errCycle;
    logic [31:0] aluId;
    logic [31:0] aluA;
    logic [31:0] aluB;
    bit          overlap;
    bit          readyBad;
  } obs_t;

  exec_controller dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .ir(ir), .id(id), .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data), .rt_data(rt_data),
    .alu_id(alu_id), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .pc_load(pc_load), .pc_target(pc_target), .busy(busy), .err(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Register file with one-cycle read latency and a simple adding ALU.
  always @(posedge clk) begin
    rs_data <= regs[rs_addr];
    rt_data <= regs[rt_addr];
  end
  assign alu_result = alu_a + alu_b;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] expv);
    vecCount++;
    if (act !== expv) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", nm, act, expv);
    end
  endtask

  function automatic logic [31:0] mkR(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    return {6'd0, rs, rt, rd, 11'd0};
  endfunction

  function automatic logic [31:0] mkI(input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
    return {6'd0, rs, rt, imm};
  endfunction

  function automatic exp_t mkExp(input bit rfWe, input logic [4:0] wa, input logic [31:0] wd,
                                 input int memCycles, input bit memWe, input logic [31:0] addr,
                                 input logic [31:0] mwd, input bit pc, input logic [31:0] tgt,
                                 input bit er, input int bsy, input bit alu,
                                 input logic [31:0] aA, input logic [31:0] aB);
    exp_t e;
    e.rfWe = rfWe; e.waddr = wa; e.wdata = wd; e.memCycles = memCycles; e.memWe = memWe;
    e.addr = addr; e.mwdata = mwd; e.pc = pc; e.target = tgt; e.err = er; e.busy = bsy;
    e.alu = alu; e.aluA = aA; e.aluB = aB;
    return e;
  endfunction

  function automatic vec_t mkVec(input logic [31:0] vId, input logic [31:0] vIr, input logic [31:0] rsV,
                                 input logic [31:0] rtV, input int d, input logic [31:0] rdata,
                                 input bit hold, input exp_t e);
    vec_t v;
    v.id = vId; v.ir = vIr; v.rsV = rsV; v.rtV = rtV; v.d = d; v.rdata = rdata; v.hold = hold; v.e = e;
    return v;
  endfunction

  // Behavioural model: what an instruction should do, from its class and the bench's memory delay.
  function automatic exp_t predict(input logic [31:0] vId, input logic [31:0] vIr, input logic [31:0] a,
                                   input logic [31:0] b, input int d, input logic [31:0] rdata);
    exp_t e;
    logic [31:0] imm;
    int n;
    e = '0;
    imm = {{16{vIr[15]}}, vIr[15:0]};
    if (vId inside {1, 3, 5, 7, 9, 11, 22, 23, 24, 2, 4, 6, 8, 10, 12}) begin
      bit isR;
      isR = vId inside {1, 3, 5, 7, 9, 11, 22, 23, 24};
      e.alu = 1; e.aluA = a; e.aluB = isR ? b : imm;
      e.wdata = a + e.aluB;
      e.waddr = isR ? vIr[15:11] : vIr[20:16];
      e.rfWe = (e.waddr != 0);
      e.busy = 3;
    end else if (vId == 13 || vId == 14) begin
      n = d + 1;
      e.memWe = (vId == 14); e.addr = a + imm; e.mwdata = b;
`ifdef EXEC_CTRL_MEM_TIMEOUT_EN
      if (n > 16) begin
        e.memCycles = 16; e.err = 1; e.busy = 18;
        return e;
      end
`endif
      e.memCycles = n;
      if (vId == 13) begin
        e.waddr = vIr[20:16]; e.wdata = rdata; e.rfWe = (e.waddr != 0); e.busy = 2 + n + 1;
      end else begin
        e.busy = 2 + n;
      end
    end else if (vId == 21) begin
      e.pc = 1; e.target = {6'd0, vIr[25:0]}; e.busy = 2;
    end else begin
      e.err = 1; e.busy = 2;
    end
    return e;
  endfunction

  // Issue one instruction, act as memory, and record what the DUT did on every cycle until idle.
  task automatic applyStimulus(input vec_t v, output obs_t o);
    int memK;
    o = '0;
    o.hung = 1;
    memK = 0;
    @(negedge clk);
    regs[v.ir[25:21]] = v.rsV;
    regs[v.ir[20:16]] = v.rtV;
    ir = v.ir; id = v.id; instr_valid = 1'b1; mem_ack = 1'b0;
    @(posedge clk);
    for (int n = 1; n <= 80; n++) begin
      @(negedge clk);
      if (rf_we) begin
        o.rfCnt++; o.rfCycle = n; o.waddr = rf_waddr; o.wdata = rf_wdata;
      end
      if (mem_req) begin
        memK++;
        if (memK == 1) begin
          o.addr = mem_addr; o.mwdata = mem_wdata; o.memWe = mem_we;
        end else if (mem_addr !== o.addr || mem_wdata !== o.mwdata || mem_we !== o.memWe) begin
          o.unstable = 1;
        end
      end
      o.memCnt = memK;
      if (pc_load) begin
        o.pcCnt++; o.pcCycle = n; o.target = pc_target;
      end
      if (err) begin
        o.errCnt++; o.errCycle = n;
      end
      if (n == 2) begin
        o.aluId = alu_id; o.aluA = alu_a; o.aluB = alu_b;
      end
      if ((int'(rf_we) + int'(mem_req) + int'(pc_load)) > 1) o.overlap = 1;
      if (busy === instr_ready) o.readyBad = 1;
      mem_ack = mem_req ? (memK == v.d + 1) : 1'($urandom_range(0, 1));
      mem_rdata = (mem_req && memK == v.d + 1) ? v.rdata : $urandom;
      if (v.hold) begin
        ir = $urandom; id = $urandom_range(1, 14);
      end else begin
        instr_valid = 1'b0;
      end
      if (instr_ready) begin
        o.busy = n - 1; o.hung = 0;
        break;
      end
    end
    instr_valid = 1'b0;
    mem_ack = 1'b0;
  endtask

  task automatic checkOutput(input string t, input vec_t v, input obs_t o);
    cmp({t, ".completes"}, 32'(o.hung), 32'd0);
    cmp({t, ".busyCycles"}, o.busy, v.e.busy);
    cmp({t, ".rfWeCount"}, o.rfCnt, 32'(v.e.rfWe));
    if (v.e.rfWe) begin
      cmp({t, ".rfWeCycle"}, o.rfCycle, v.e.busy);
      cmp({t, ".rfWaddr"}, 32'(o.waddr), 32'(v.e.waddr));
      cmp({t, ".rfWdata"}, o.wdata, v.e.wdata);
    end
    cmp({t, ".memReqCycles"}, o.memCnt, v.e.memCycles);
    if (v.e.memCycles != 0) begin
      cmp({t, ".memAddr"}, o.addr, v.e.addr);
      cmp({t, ".memWdata"}, o.mwdata, v.e.mwdata);
      cmp({t, ".memWe"}, 32'(o.memWe), 32'(v.e.memWe));
      cmp({t, ".memStable"}, 32'(o.unstable), 32'd0);
    end
    cmp({t, ".pcLoadCount"}, o.pcCnt, 32'(v.e.pc));
    if (v.e.pc) begin
      cmp({t, ".pcLoadCycle"}, o.pcCycle, 32'd2);
      cmp({t, ".pcTarget"}, o.target, v.e.target);
    end
    cmp({t, ".errCount"}, o.errCnt, 32'(v.e.err));
    if (v.e.err) cmp({t, ".errCycle"}, o.errCycle, (v.e.memCycles != 0) ? v.e.busy + 1 : 2);
    if (v.e.alu) begin
      cmp({t, ".aluId"}, o.aluId, v.id);
      cmp({t, ".aluA"}, o.aluA, v.e.aluA);
      cmp({t, ".aluB"}, o.aluB, v.e.aluB);
    end
    cmp({t, ".exclusive"}, 32'(o.overlap), 32'd0);
    cmp({t, ".readyBusy"}, 32'(o.readyBad), 32'd0);
  endtask

  task automatic runVec(input string t, input vec_t v);
    obs_t o;
    applyStimulus(v, o);
    checkOutput(t, v, o);
  endtask

  vec_t vecs [15];

  initial begin
    obs_t o;
    vec_t v;
    logic [31:0] rId, rIr, rsV, rtV, a, b;
    int d, seen;

    for (int i = 0; i < 32; i++) regs[i] = 32'd0;
    reset = 1'b1; instr_valid = 1'b0; ir = 32'd0; id = 32'd0; mem_ack = 1'b0; mem_rdata = 32'd0;

    vecs[0]  = mkVec(1,  mkR(2, 3, 1), 10, 12, 0, 0, 0, mkExp(1, 1, 22, 0, 0, 0, 0, 0, 0, 0, 3, 1, 10, 12));
    vecs[1]  = mkVec(10, mkI(2, 1, 99), 10, 7, 0, 0, 0, mkExp(1, 1, 109, 0, 0, 0, 0, 0, 0, 0, 3, 1, 10, 99));
    vecs[2]  = mkVec(1,  mkR(2, 3, 0), 10, 12, 0, 0, 0, mkExp(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 1, 10, 12));
    vecs[3]  = mkVec(4,  mkI(2, 5, 16'hFFF0), 100, 3, 0, 0, 0,
                     mkExp(1, 5, 84, 0, 0, 0, 0, 0, 0, 0, 3, 1, 100, 32'hFFFF_FFF0));
    vecs[4]  = mkVec(13, mkI(2, 1, 100), 10, 32'h77, 2, 32'h55, 0,
                     mkExp(1, 1, 32'h55, 3, 0, 110, 32'h77, 0, 0, 0, 6, 0, 0, 0));
    vecs[5]  = mkVec(14, mkI(2, 3, 100), 10, 12, 0, 0, 0, mkExp(0, 0, 0, 1, 1, 110, 12, 0, 0, 0, 3, 0, 0, 0));
    vecs[6]  = mkVec(21, 32'd100, 0, 0, 0, 0, 0, mkExp(0, 0, 0, 0, 0, 0, 0, 1, 100, 0, 2, 0, 0, 0));
    vecs[7]  = mkVec(31, mkR(1, 2, 3), 5, 6, 0, 0, 0, mkExp(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0));
    vecs[8]  = mkVec(3,  mkR(4, 6, 9), 5, 32'hFFFF_FFFF, 0, 0, 1,
                     mkExp(1, 9, 4, 0, 0, 0, 0, 0, 0, 0, 3, 1, 5, 32'hFFFF_FFFF));
    vecs[9]  = mkVec(13, mkI(2, 7, 16'hFFF8), 4, 32'hABCD, 0, 32'hDEAD, 0,
                     mkExp(1, 7, 32'hDEAD, 1, 0, 32'hFFFF_FFFC, 32'hABCD, 0, 0, 0, 4, 0, 0, 0));
    vecs[10] = mkVec(21, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, mkExp(0, 0, 0, 0, 0, 0, 0, 1, 32'h03FF_FFFF, 0, 2, 0, 0, 0));
    vecs[11] = mkVec(13, mkI(3, 0, 8), 20, 5, 1, 1, 0, mkExp(0, 0, 0, 2, 0, 28, 5, 0, 0, 0, 5, 0, 0, 0));
    vecs[12] = mkVec(15, mkR(1, 2, 3), 0, 0, 0, 0, 0, mkExp(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0));
    vecs[13] = mkVec(22, mkR(8, 9, 31), 1, 2, 0, 0, 0, mkExp(1, 31, 3, 0, 0, 0, 0, 0, 0, 0, 3, 1, 1, 2));
    vecs[14] = mkVec(0,  mkR(1, 2, 3), 0, 0, 0, 0, 0, mkExp(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0));

    repeat (3) @(posedge clk);
    @(negedge clk);
    cmp("reset.instrReady", 32'(instr_ready), 32'd1);
    cmp("reset.busy", 32'(busy), 32'd0);
    cmp("reset.strobes", {28'd0, rf_we, mem_req, pc_load, err}, 32'd0);
    cmp("reset.otherOutputsZero",
        32'(|{rs_addr, rt_addr, alu_id, alu_a, alu_b, mem_we, mem_addr, mem_wdata, rf_waddr, rf_wdata, pc_target}),
        32'd0);
    reset = 1'b0;

    for (int i = 0; i < 15; i++) runVec($sformatf("vec%0d", i), vecs[i]);

    // Memory wait right at the 16-cycle limit, and well beyond it.
    runVec("memAck16", mkVec(13, mkI(2, 1, 4), 8, 9, 15, 32'h1234, 0, predict(13, mkI(2, 1, 4), 8, 9, 15, 32'h1234)));
    runVec("memNoAck", mkVec(14, mkI(2, 3, 4), 8, 9, 40, 0, 0, predict(14, mkI(2, 3, 4), 8, 9, 40, 0)));

    for (int i = 0; i < 40; i++) begin
      rId = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 25));
      rIr = $urandom; rsV = $urandom; rtV = $urandom;
      d = ($urandom_range(0, 7) == 0) ? $urandom_range(12, 20) : $urandom_range(0, 3);
      a = (rIr[25:21] == rIr[20:16]) ? rtV : rsV;
      b = rtV;
      v = mkVec(rId, rIr, rsV, rtV, d, $urandom, 1'($urandom_range(0, 1)), 0);
      v.e = predict(rId, rIr, a, b, d, v.rdata);
      runVec($sformatf("rand%0d_id%0d", i, rId), v);
    end

    // Reset while a load is waiting in MEM, with valid and ack also high on the reset edge.
    @(negedge clk);
    regs[2] = 32'd10;
    ir = mkI(2, 1, 100); id = 32'd13; instr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    seen = 0;
    for (int n = 0; n < 10 && !seen; n++) begin
      @(negedge clk);
      if (mem_req) seen = 1;
    end
    cmp("rstMem.memReqBefore", 32'(seen), 32'd1);
    reset = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h99; instr_valid = 1'b1; id = 32'd1;
    @(posedge clk);
    @(negedge clk);
    cmp("rstMem.memReqAfter", 32'(mem_req), 32'd0);
    cmp("rstMem.instrReady", 32'(instr_ready), 32'd1);
    cmp("rstMem.busy", 32'(busy), 32'd0);
    reset = 1'b0; mem_ack = 1'b0; instr_valid = 1'b0;
    seen = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (rf_we || busy) seen++;
    end
    cmp("rstMem.noLaterActivity", seen, 32'd0);

    runVec("afterReset", vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
